// File: rtl/fir_host_driver_if.sv
// AXI-Lite control bus plus the two AXI-Stream data buses between the host driver and the FIR core.
interface fir_host_driver_if #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32
);
   logic                   awvalid, awready;
   logic [pADDR_WIDTH-1:0] awaddr;
   logic                   wvalid, wready;
   logic [pDATA_WIDTH-1:0] wdata;
   logic                   arvalid, arready;
   logic [pADDR_WIDTH-1:0] araddr;
   logic                   rvalid, rready;
   logic [pDATA_WIDTH-1:0] rdata;
   logic                   ss_tvalid, ss_tready, ss_tlast;
   logic [pDATA_WIDTH-1:0] ss_tdata;
   logic                   sm_tvalid, sm_tready, sm_tlast;
   logic [pDATA_WIDTH-1:0] sm_tdata;

   modport master (
      output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
             ss_tvalid, ss_tdata, ss_tlast, sm_tready,
      input  awready, wready, arready, rvalid, rdata,
             ss_tready, sm_tvalid, sm_tdata, sm_tlast
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
             ss_tvalid, ss_tdata, ss_tlast, sm_tready,
      output awready, wready, arready, rvalid, rdata,
             ss_tready, sm_tvalid, sm_tdata, sm_tlast
   );
endinterface

// File: rtl/fir_host_driver.sv
// Host-side sequencer for the FIR core: checks ap_idle, programs length and taps, starts the core,
// streams samples in and results out concurrently, then polls ap_done.
module fir_host_driver #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11,
   parameter int pPOLL_MAX   = 1024
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   start,
   input  logic [31:0]            len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [3:0]             tap_idx,
   input  logic [pDATA_WIDTH-1:0] tap_val,
   input  logic                   src_valid,
   output logic                   src_ready,
   input  logic [pDATA_WIDTH-1:0] src_data,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [pDATA_WIDTH-1:0] res_data,
   output logic                   res_last,
   fir_host_driver_if.master      fir
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] CHK_IDLE = 3'd1;
   localparam logic [2:0] WR_LEN   = 3'd2;
   localparam logic [2:0] WR_TAP   = 3'd3;
   localparam logic [2:0] WR_START = 3'd4;
   localparam logic [2:0] STREAM   = 3'd5;
   localparam logic [2:0] POLL     = 3'd6;
   localparam logic [2:0] FIN      = 3'd7;

   localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
   localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(12'h010);
   localparam logic [pADDR_WIDTH-1:0] ADDR_TAP  = pADDR_WIDTH'(12'h020);
   localparam logic [3:0]             LAST_TAP  = 4'(Tape_Num - 1);
   localparam logic [31:0]            POLL_LAST = 32'(pPOLL_MAX - 1);

   logic [2:0]             state;
   logic [31:0]            len_r, sent, rcvd, poll_cnt;
   logic                   op_busy;
   logic                   awvalid_r, wvalid_r, arvalid_r, rready_r;
   logic [pADDR_WIDTH-1:0] awaddr_r, araddr_r;
   logic [pDATA_WIDTH-1:0] wdata_r;

   logic                   in_stream, send_open, recv_open, ss_hs, sm_hs;
   logic                   wr_state, rd_state, wr_done, rd_done;
   logic [pADDR_WIDTH-1:0] wr_addr;
   logic [pDATA_WIDTH-1:0] wr_data;
   logic                   unused_rdata;

   assign fir.awvalid = awvalid_r;
   assign fir.awaddr  = awaddr_r;
   assign fir.wvalid  = wvalid_r;
   assign fir.wdata   = wdata_r;
   assign fir.arvalid = arvalid_r;
   assign fir.araddr  = araddr_r;
   assign fir.rready  = rready_r;

   // Both stream directions are gated by their own counters so neither can run past len.
   assign in_stream     = (state == STREAM);
   assign send_open     = in_stream && (sent < len_r);
   assign recv_open     = in_stream && (rcvd < len_r);
   assign fir.ss_tvalid = send_open && src_valid;
   assign fir.ss_tdata  = in_stream ? src_data : '0;
   assign fir.ss_tlast  = in_stream && (sent == len_r - 32'd1);
   assign src_ready     = send_open && fir.ss_tready;
   assign fir.sm_tready = recv_open && res_ready;
   assign res_valid     = recv_open && fir.sm_tvalid;
   assign res_data      = in_stream ? fir.sm_tdata : '0;
   assign res_last      = in_stream && (rcvd == len_r - 32'd1);
   assign ss_hs         = fir.ss_tvalid && fir.ss_tready;
   assign sm_hs         = fir.sm_tvalid && fir.sm_tready;

   assign wr_state = (state == WR_LEN) || (state == WR_TAP) || (state == WR_START);
   assign rd_state = (state == CHK_IDLE) || (state == POLL);
   // A write is finished once each channel has either already handshaken or handshakes now.
   assign wr_done  = op_busy && wr_state && (!awvalid_r || fir.awready) && (!wvalid_r || fir.wready);
   assign rd_done  = op_busy && rd_state && rready_r && fir.rvalid;
   assign unused_rdata = ^{fir.rdata[pDATA_WIDTH-1:3], fir.rdata[0]};

   // NOTE: every output of an always_comb gets a default first, otherwise unlisted states infer latches.
   always_comb begin
      wr_addr = ADDR_CTRL;
      wr_data = '0;
      case (state)
         WR_LEN: begin
            wr_addr = ADDR_LEN;
            wr_data = pDATA_WIDTH'(len_r);
         end
         WR_TAP: begin
            wr_addr = ADDR_TAP + pADDR_WIDTH'({tap_idx, 2'b00});
            wr_data = tap_val;
         end
         WR_START: wr_data = pDATA_WIDTH'(1);
         default: ;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         tap_idx   <= '0;
         len_r     <= '0;
         sent      <= '0;
         rcvd      <= '0;
         poll_cnt  <= '0;
         op_busy   <= 1'b0;
         awvalid_r <= 1'b0;
         wvalid_r  <= 1'b0;
         arvalid_r <= 1'b0;
         rready_r  <= 1'b0;
         awaddr_r  <= '0;
         araddr_r  <= '0;
         wdata_r   <= '0;
      end else begin
         done <= 1'b0;
         if (ss_hs) sent <= sent + 32'd1;
         if (sm_hs) begin
            rcvd <= rcvd + 32'd1;
            if (fir.sm_tlast != (rcvd == len_r - 32'd1)) err <= 1'b1;
         end

         if (wr_state) begin
            if (!op_busy) begin
               awvalid_r <= 1'b1;
               wvalid_r  <= 1'b1;
               awaddr_r  <= wr_addr;
               wdata_r   <= wr_data;
               op_busy   <= 1'b1;
            end else begin
               if (awvalid_r && fir.awready) awvalid_r <= 1'b0;
               if (wvalid_r && fir.wready)   wvalid_r  <= 1'b0;
               if (wr_done)                  op_busy   <= 1'b0;
            end
         end

         if (rd_state) begin
            if (!op_busy) begin
               arvalid_r <= 1'b1;
               araddr_r  <= ADDR_CTRL;
               op_busy   <= 1'b1;
            end else begin
               if (arvalid_r && fir.arready) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
               end
               if (rd_done) begin
                  rready_r <= 1'b0;
                  op_busy  <= 1'b0;
               end
            end
         end

         case (state)
            IDLE: if (start) begin
               if (len != 32'd0) begin
                  state    <= CHK_IDLE;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  len_r    <= len;
                  sent     <= '0;
                  rcvd     <= '0;
                  poll_cnt <= '0;
               end else begin
                  done <= 1'b1;
                  err  <= 1'b1;
               end
            end
            CHK_IDLE: if (rd_done) begin
               if (fir.rdata[2]) state <= WR_LEN;
               else begin
                  err   <= 1'b1;
                  state <= FIN;
               end
            end
            WR_LEN: if (wr_done) begin
               tap_idx <= '0;
               state   <= WR_TAP;
            end
            WR_TAP: if (wr_done) begin
               if (tap_idx == LAST_TAP) begin
                  tap_idx <= '0;
                  state   <= WR_START;
               end else tap_idx <= tap_idx + 4'd1;
            end
            WR_START: if (wr_done) state <= STREAM;
            STREAM: if (sent == len_r && rcvd == len_r) state <= POLL;
            POLL: if (rd_done) begin
               poll_cnt <= poll_cnt + 32'd1;
               if (fir.rdata[1]) state <= FIN;
               else if (poll_cnt == POLL_LAST) begin
                  err   <= 1'b1;
                  state <= FIN;
               end
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_host_driver.sv
// Directed bench: a behavioural FIR core on the bus side, scripted host stimulus, hand-computed results.
`timescale 1ns/1ps
module tb_fir_host_driver;
   localparam int AW = 12, DW = 32, NTAP = 11, PMAX = 1024;

   logic          axis_clk = 1'b0, axis_rst_n = 1'b0;
   logic          start = 1'b0;
   logic [31:0]   len = '0;
   logic          busy, done, err;
   logic [3:0]    tap_idx;
   logic [DW-1:0] tap_val, src_data, res_data;
   logic          src_valid, src_ready, res_valid, res_ready, res_last;

   fir_host_driver_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) fir ();

   fir_host_driver #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NTAP), .pPOLL_MAX(PMAX)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .len(len),
      .busy(busy), .done(done), .err(err), .tap_idx(tap_idx), .tap_val(tap_val),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
      .fir(fir)
   );

   always #5 axis_clk = ~axis_clk;

   // scenario knobs, written only by the main initial block
   int   wr_mode = 0, n_src = 0;
   logic idle_bit = 1'b1, never_done = 1'b0, bad_tlast = 1'b0, bp_en = 1'b0;
   logic ss_rdy_g = 1'b1, sm_vld_g = 1'b1, res_rdy_g = 1'b1;

   // behavioural FIR core and host-side monitors
   logic          aw_got, w_got, rd_pend;
   logic [AW-1:0] cap_addr, wa [0:15];
   logic [DW-1:0] cap_data, wd [0:15], m_len, m_tap [0:NTAP-1];
   logic [DW-1:0] x [0:31], y_q [0:31], res_q [0:31], y_next;
   int wr_cnt, dup_cnt, rd_cnt, rd_at_w0, fin_cnt, fout_cnt, src_idx, viol, busact;
   int ss_last_cnt, ss_last_idx, res_cnt, res_last_cnt, res_last_idx;

   logic          aw_now, w_now, a_all, b_all, done_bit, is_tap;
   logic [AW-1:0] ca;
   logic [DW-1:0] cd;
   int            tap_slot;

   assign tap_val   = DW'(tap_idx) + 1;
   assign src_valid = (src_idx < n_src);
   assign src_data  = DW'(src_idx + 1);
   assign res_ready = res_rdy_g;

   assign fir.awready = (wr_mode == 2) ? w_got  : 1'b1;
   assign fir.wready  = (wr_mode == 1) ? aw_got : 1'b1;
   assign fir.arready = 1'b1;
   assign fir.rvalid  = rd_pend;
   assign done_bit    = !never_done && (m_len != 0) && (fout_cnt == int'(m_len));
   assign fir.rdata   = {29'd0, idle_bit, done_bit, 1'b0};
   assign fir.ss_tready = ss_rdy_g;
   assign fir.sm_tvalid = (fout_cnt < fin_cnt) && sm_vld_g;
   assign fir.sm_tdata  = (fout_cnt < 32) ? y_q[fout_cnt] : '0;
   assign fir.sm_tlast  = (fout_cnt == int'(m_len) - 1) || (bad_tlast && fout_cnt == 1);

   assign aw_now   = fir.awvalid && fir.awready;
   assign w_now    = fir.wvalid && fir.wready;
   assign a_all    = aw_got || aw_now;
   assign b_all    = w_got || w_now;
   assign ca       = aw_now ? fir.awaddr : cap_addr;
   assign cd       = w_now ? fir.wdata : cap_data;
   assign tap_slot = (int'(ca) - 32) / 4;
   assign is_tap   = (int'(ca) >= 32) && (tap_slot < NTAP);

   always_comb begin
      y_next = m_tap[0] * fir.ss_tdata;
      for (int k = 1; k < NTAP; k++)
         if (fin_cnt >= k && fin_cnt - k < 32) y_next = y_next + m_tap[k] * x[fin_cnt - k];
   end

   always @(negedge axis_clk) begin
      ss_rdy_g  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      sm_vld_g  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      res_rdy_g = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         aw_got <= 1'b0; w_got <= 1'b0; rd_pend <= 1'b0; cap_addr <= '0; cap_data <= '0; m_len <= '0;
         wr_cnt <= 0; dup_cnt <= 0; rd_cnt <= 0; rd_at_w0 <= -1; fin_cnt <= 0; fout_cnt <= 0;
         src_idx <= 0; viol <= 0; busact <= 0; ss_last_cnt <= 0; ss_last_idx <= -1;
         res_cnt <= 0; res_last_cnt <= 0; res_last_idx <= -1;
      end else begin
         if ((aw_now && aw_got) || (w_now && w_got)) dup_cnt <= dup_cnt + 1;
         if (a_all && b_all) begin
            if (wr_cnt < 16) begin wa[wr_cnt] <= ca; wd[wr_cnt] <= cd; end
            if (wr_cnt == 0) rd_at_w0 <= rd_cnt;
            wr_cnt <= wr_cnt + 1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            if (ca == 12'h010) m_len <= cd;
            else if (is_tap) m_tap[tap_slot] <= cd;
         end else begin
            aw_got <= a_all; w_got <= b_all; cap_addr <= ca; cap_data <= cd;
         end
         if (fir.arvalid && fir.arready) rd_pend <= 1'b1;
         if (rd_pend && fir.rready) begin rd_pend <= 1'b0; rd_cnt <= rd_cnt + 1; end
         if (fir.awvalid || fir.wvalid || fir.arvalid || fir.ss_tvalid || src_ready || res_valid)
            busact <= busact + 1;
         if (src_ready && !fir.ss_tready) viol <= viol + 1;
         if (src_valid && src_ready) src_idx <= src_idx + 1;
         if (fir.ss_tvalid && fir.ss_tready) begin
            if (fin_cnt < 32) begin x[fin_cnt] <= fir.ss_tdata; y_q[fin_cnt] <= y_next; end
            if (fir.ss_tlast) begin ss_last_cnt <= ss_last_cnt + 1; ss_last_idx <= fin_cnt; end
            fin_cnt <= fin_cnt + 1;
         end
         if (fir.sm_tvalid && fir.sm_tready) fout_cnt <= fout_cnt + 1;
         if (res_valid && res_ready) begin
            if (res_cnt < 32) res_q[res_cnt] <= res_data;
            if (res_last) begin res_last_cnt <= res_last_cnt + 1; res_last_idx <= res_cnt; end
            res_cnt <= res_cnt + 1;
         end
      end
   end

   int   n_cmp = 0, n_bad = 0;
   logic err_at_done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // y[n] for inputs 1,2,3,... and taps 1..11
   function automatic logic [63:0] fir_ref(input int n);
      int acc = 0;
      for (int k = 0; k < NTAP && k <= n; k++) acc += (k + 1) * (n - k + 1);
      return 64'(acc);
   endfunction

   task automatic do_reset();
      axis_rst_n = 1'b0;
      repeat (3) @(negedge axis_clk);
      axis_rst_n = 1'b1;
      @(negedge axis_clk);
   endtask

   task automatic pulse_start(input logic [31:0] l);
      @(negedge axis_clk);
      start = 1'b1;
      len   = l;
      @(negedge axis_clk);
      start = 1'b0;
      len   = '0;
   endtask

   task automatic run(input string tag, input logic [31:0] l, input int budget);
      int cyc = 0;
      pulse_start(l);
      check({tag, "_busy"}, busy, 1);
      while (!done && cyc < budget) begin
         @(negedge axis_clk);
         cyc++;
      end
      check({tag, "_done_seen"}, done, 1);
      check({tag, "_busy_at_done"}, busy, 0);
      err_at_done = err;
      @(negedge axis_clk);
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_valids", {fir.awvalid, fir.wvalid, fir.arvalid, fir.rready, fir.ss_tvalid, fir.sm_tready}, 0);
      check("rst_addr_data", {fir.awaddr, fir.araddr, fir.wdata, tap_idx}, 0);
      repeat (5) @(negedge axis_clk);
      check("idle_no_bus", busact, 0);

      // zero-length request: immediate error pulse, nothing on the buses
      pulse_start(32'd0);
      check("len0_done", done, 1);
      check("len0_err", err, 1);
      check("len0_busy", busy, 0);
      @(negedge axis_clk);
      check("len0_done_pulse", done, 0);
      check("len0_no_bus", busact, 0);

      // ideal run, len=4, always ready
      n_src = 4;
      do_reset();
      run("basic", 32'd4, 500);
      check("basic_err", err_at_done, 0);
      check("basic_wr_cnt", wr_cnt, 13);
      check("basic_chk_first", rd_at_w0, 1);
      check("basic_len_addr", wa[0], 12'h010);
      check("basic_len_data", wd[0], 4);
      for (int i = 0; i < NTAP; i++) begin
         check($sformatf("basic_tap%0d_addr", i), wa[1 + i], 64'(32 + 4 * i));
         check($sformatf("basic_tap%0d_data", i), wd[1 + i], 64'(i + 1));
      end
      check("basic_start_addr", wa[12], 0);
      check("basic_start_data", wd[12], 1);
      check("basic_ss_beats", fin_cnt, 4);
      check("basic_ss_tlast", {32'(ss_last_cnt), 32'(ss_last_idx)}, {32'd1, 32'd3});
      check("basic_res_cnt", res_cnt, 4);
      check("basic_res0", res_q[0], 1);
      check("basic_res1", res_q[1], 4);
      check("basic_res2", res_q[2], 10);
      check("basic_res3", res_q[3], 20);
      check("basic_res_last", {32'(res_last_cnt), 32'(res_last_idx)}, {32'd1, 32'd3});
      check("basic_polls", rd_cnt, 2);

      // skewed write handshakes: awready first, then wready first
      for (int m = 1; m <= 2; m++) begin
         wr_mode = m;
         n_src = 2;
         do_reset();
         run($sformatf("skew%0d", m), 32'd2, 800);
         check($sformatf("skew%0d_err", m), err_at_done, 0);
         check($sformatf("skew%0d_wr_cnt", m), wr_cnt, 13);
         check($sformatf("skew%0d_dup", m), dup_cnt, 0);
         check($sformatf("skew%0d_len", m), {wa[0], wd[0]}, {12'h010, 32'd2});
         check($sformatf("skew%0d_tap5", m), {wa[6], wd[6]}, {12'h034, 32'd6});
         check($sformatf("skew%0d_start", m), {wa[12], wd[12]}, {12'h000, 32'd1});
         check($sformatf("skew%0d_res", m), {res_q[0], res_q[1]}, {32'd1, 32'd4});
      end
      wr_mode = 0;

      // random back-pressure, len=16
      n_src = 16;
      bp_en = 1'b1;
      do_reset();
      run("bp", 32'd16, 3000);
      bp_en = 1'b0;
      check("bp_err", err_at_done, 0);
      check("bp_ss_beats", fin_cnt, 16);
      check("bp_res_cnt", res_cnt, 16);
      check("bp_ready_viol", viol, 0);
      check("bp_tlasts", {32'(ss_last_idx), 32'(res_last_idx)}, {32'd15, 32'd15});
      for (int i = 0; i < 16; i++) check($sformatf("bp_res%0d", i), res_q[i], fir_ref(i));

      // core not idle
      idle_bit = 1'b0;
      n_src = 4;
      do_reset();
      run("notidle", 32'd4, 200);
      idle_bit = 1'b1;
      check("notidle_err", err_at_done, 1);
      check("notidle_writes", wr_cnt, 0);
      check("notidle_reads", rd_cnt, 1);

      // ap_done never set
      never_done = 1'b1;
      n_src = 1;
      do_reset();
      run("timeout", 32'd1, 8000);
      never_done = 1'b0;
      check("timeout_err", err_at_done, 1);
      check("timeout_reads", rd_cnt, 1 + PMAX);

      // sm_tlast on result 2
      bad_tlast = 1'b1;
      n_src = 4;
      do_reset();
      run("badlast", 32'd4, 500);
      bad_tlast = 1'b0;
      check("badlast_err", err_at_done, 1);
      check("badlast_res_cnt", res_cnt, 4);
      check("badlast_res3", res_q[3], 20);

      // reset in the middle of the tap writes, then a clean restart
      n_src = 4;
      do_reset();
      pulse_start(32'd4);
      begin
         int cyc = 0;
         while (!(tap_idx == 4'd5 && fir.awvalid) && cyc < 200) begin
            @(negedge axis_clk);
            cyc++;
         end
         check("midrst_reached_tap5", {28'd0, tap_idx, 31'd0, fir.awvalid}, {28'd0, 4'd5, 31'd0, 1'b1});
      end
      #1 axis_rst_n = 1'b0;
      #1;
      check("midrst_awvalid", fir.awvalid, 0);
      check("midrst_wvalid", fir.wvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_tap_idx", tap_idx, 0);
      repeat (2) @(negedge axis_clk);
      axis_rst_n = 1'b1;
      repeat (5) @(negedge axis_clk);
      check("midrst_quiet", busact, 0);
      run("restart", 32'd4, 500);
      check("restart_err", err_at_done, 0);
      check("restart_chk_first", rd_at_w0, 1);
      check("restart_wr_cnt", wr_cnt, 13);
      check("restart_res3", res_q[3], 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fir_host_driver.md
FIR_HOST_DRIVER -- requirements
Module: fir_host_driver

Interface
REQ-001 The block SHALL have parameter pADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 The block SHALL have parameter pDATA_WIDTH, default 32, data width of all buses.
REQ-003 The block SHALL have parameter Tape_Num, default 11, number of FIR coefficients written.
REQ-004 The block SHALL have parameter pPOLL_MAX, default 1024, maximum ap_done poll reads before error.
REQ-005 The block SHALL have these ports; clock axis_clk (in, 1) and reset axis_rst_n (in, 1) come first, and axis_rst_n is asynchronous, active-low:
- axis_clk in 1 clock; axis_rst_n in 1 asynchronous active-low reset
- start in 1 one-cycle run request; len in 32 sample count; busy out 1; done out 1 one-cycle pulse; err out 1 sticky until next start
- tap_idx out 4 coefficient index; tap_val in pDATA_WIDTH coefficient for tap_idx, combinational
- src_valid in 1, src_ready out 1, src_data in pDATA_WIDTH: sample source
- res_valid out 1, res_ready in 1, res_data out pDATA_WIDTH, res_last out 1: result sink
- AXI-Lite master: awvalid out, awready in, awaddr out pADDR_WIDTH, wvalid out, wready in, wdata out pDATA_WIDTH, arvalid out, arready in, araddr out pADDR_WIDTH, rvalid in, rready out, rdata in pDATA_WIDTH
- AXI-Stream to FIR: ss_tvalid out, ss_tready in, ss_tdata out pDATA_WIDTH, ss_tlast out
- AXI-Stream from FIR: sm_tvalid in, sm_tready out, sm_tdata in pDATA_WIDTH, sm_tlast in

Function
REQ-006 The FSM SHALL have states IDLE, CHK_IDLE, WR_LEN, WR_TAP, WR_START, STREAM, POLL, FIN.
REQ-007 In IDLE, start=1 with len!=0 SHALL move to CHK_IDLE, clear err, and set busy=1 next cycle; start with len==0 SHALL pulse done and set err, with no bus traffic.
REQ-008 start SHALL be ignored in every state except IDLE.
REQ-009 AXI-Lite write: awvalid and wvalid SHALL assert together; each SHALL drop the cycle after its own handshake (valid&ready); the write completes when both have handshaken, in any order or the same cycle.
REQ-010 awaddr/wdata SHALL be held stable while the corresponding valid is high.
REQ-011 AXI-Lite read: arvalid SHALL hold until arready; rready SHALL then assert and hold until rvalid; rdata SHALL be sampled on the rvalid&rready cycle.
REQ-012 CHK_IDLE SHALL read address 0x00; bit2 (ap_idle)=1 SHALL go to WR_LEN, otherwise set err and go to FIN.
REQ-013 WR_LEN SHALL write len to 0x10.
REQ-014 WR_TAP SHALL write tap_val to 0x20+4*i for i=0..Tape_Num-1 in ascending order, with tap_idx=i; after the last tap it SHALL go to WR_START.
REQ-015 WR_START SHALL write 0x0000_0001 to 0x00 and then enter STREAM.
REQ-016 In STREAM: ss_tvalid=src_valid&&(sent<len); ss_tdata=src_data; src_ready=ss_tready&&(sent<len); ss_tlast=1 when sent==len-1. sent SHALL increment on each ss handshake.
REQ-017 In STREAM: sm_tready=res_ready&&(rcvd<len); res_valid=sm_tvalid&&(rcvd<len); res_data=sm_tdata; res_last=1 when rcvd==len-1. rcvd SHALL increment on each sm handshake.
REQ-018 Input and output streams SHALL run concurrently and independently; no sample ordering is imposed between them.
REQ-019 sm_tlast on a handshake SHALL equal (rcvd==len-1); a mismatch SHALL set err and SHALL NOT stop the stream.
REQ-020 STREAM SHALL exit to POLL when sent==len and rcvd==len.
REQ-021 POLL SHALL repeatedly read 0x00 until bit1 (ap_done)=1, then go to FIN; after pPOLL_MAX reads without ap_done it SHALL set err and go to FIN.
REQ-022 FIN SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-023 Outside their own phase, all valid and ready outputs SHALL be 0, and src_ready and res_valid SHALL be 0.
REQ-024 sent, rcvd and the poll counter SHALL be 32-bit and SHALL NOT wrap, because exit happens at len.

Reset
REQ-025 On axis_rst_n=0 the FSM SHALL go to IDLE asynchronously, and all outputs SHALL become 0 (valids, readies, busy, done, err, addresses, data, tap_idx, tlasts, res_last), including during a transaction in progress.
REQ-026 After reset release, no bus activity SHALL occur until start.

Verification
REQ-027 Bench: len=4, taps 1..11, ideal FIR model with always-ready handshakes -> writes 0x10=4, 0x20..0x48=1..11, 0x00=1; 4 ss beats with tlast on the 4th; 4 results with res_last on the 4th; then done=1, err=0.
REQ-028 Bench: awready one cycle before wready on every write, then the reverse -> each write completes exactly once with correct addr/data, and no duplicate valid.
REQ-029 Bench: random back-pressure on ss_tready, sm_tvalid and res_ready, len=16 -> exactly 16 beats each way in order, and src_ready never high while ss_tready=0.
REQ-030 Bench: ap_idle read as 0 in CHK_IDLE -> err=1, done pulse, no writes issued; separately, ap_done never set -> err=1 after pPOLL_MAX=1024 reads.
REQ-031 Bench: sm_tlast asserted on result 2 of len=4 -> err=1, and all 4 results are still delivered.
REQ-032 Bench: reset asserted mid WR_TAP (i=5) -> awvalid, wvalid and busy are 0 immediately; a fresh start restarts from CHK_IDLE.
